// File: rtl/div32_seq.sv
// div32_seq: sequential 32-bit restoring divider (quotient on LO, remainder on HI).
// Optional feature macro: DIV32_SEQ_SIGNED_EN enables two's-complement operands via i_signed;
// without it every operation is unsigned and i_signed is ignored.
// Timing: START accepted at edge k -> 32 shift-subtract steps at edges k+1..k+32,
// sign correction and writeback at edge k+33 (enters FIN, DONE high), IDLE again at k+34.
module div32_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div0
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_bz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div0;

    logic        w_accept;
    logic        w_step;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [33:0] w_trial;
    logic        w_fits;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_accept = (r_state == IDLE) && i_start;
    // r_cnt[5] set means all 32 steps are done; that CALC cycle only does the writeback
    assign w_step   = (r_state == CALC) && !r_cnt[5];
    assign w_last   = (r_state == CALC) &&  r_cnt[5];

`ifdef DIV32_SEQ_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;

    assign w_neg_a = i_signed & i_a[31];
    assign w_neg_b = i_signed & i_b[31];
    assign w_mag_a = w_neg_a ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = w_neg_b ? (~i_b + 32'd1) : i_b;
    // Truncation toward zero: quotient sign is the xor of operand signs, remainder follows the dividend
    assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // Operand signs captured with START and held for the final correction
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = i_signed;
    assign w_mag_a = i_a;
    assign w_mag_b = i_b;
    assign w_q_fix = r_quo;
    assign w_r_fix = r_rem;
`endif

    // Restoring trial subtraction on the partial remainder shifted by one dividend bit;
    // the extra top bit keeps the borrow visible for every divisor including zero
    assign w_trial = {1'b0, r_rem, r_quo[31]} - {2'b00, r_div};
    assign w_fits  = ~w_trial[33];

    // State register, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: START is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = CALC;
            CALC:    if (r_cnt[5]) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        o_busy = (r_state != IDLE);
        o_done = (r_state == FIN);
    end

    // Iteration counter: zeroed on accept, counts the 32 steps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_cnt <= 6'd0;
        else if (w_accept) r_cnt <= 6'd0;
        else if (w_step)   r_cnt <= r_cnt + 6'd1;
    end

    // Divider datapath: load magnitudes on accept, one shift-subtract per CALC step
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_rem <= 32'd0;
            r_quo <= w_mag_a;
            r_div <= w_mag_b;
            r_bz  <= (i_b == 32'd0);
        end else if (w_step) begin
            r_rem <= w_fits ? w_trial[31:0] : {r_rem[30:0], r_quo[31]};
            r_quo <= {r_quo[30:0], w_fits};
        end
    end

    // Result registers: written once per operation, held until the next writeback.
    // With a zero divisor the remainder path already reproduces A; only LO needs forcing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_div0 <= 1'b0;
        end else if (w_last) begin
            r_hi   <= w_r_fix;
            r_lo   <= r_bz ? 32'hFFFF_FFFF : w_q_fix;
            r_div0 <= r_bz;
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_div0 = r_div0;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: stimulus pushes expected results (from an arithmetic
// reference model) with the cycle DONE must appear; a monitor pops on every DONE.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    logic        last_dz = 1'b0;

    div32_seq dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_signed (sgn),
        .i_a      (a),
        .i_b      (b),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_busy   (busy),
        .o_done   (done),
        .o_div0   (div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic, truncating signed division, documented special cases
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
        exp_t e;
        logic use_s;
        int   sa;
        int   sbv;
`ifdef DIV32_SEQ_SIGNED_EN
        use_s = ms;
`else
        use_s = 1'b0;
        if (ms) use_s = 1'b0;
`endif
        e.cyc = 0;
        e.dz  = 1'b0;
        if (mb == 32'd0) begin
            e.hi = ma;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else if (use_s) begin
            if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'd0;
            end else begin
                sa   = signed'(ma);
                sbv  = signed'(mb);
                e.lo = sa / sbv;
                e.hi = sa % sbv;
            end
        end else begin
            e.lo = ma / mb;
            e.hi = ma % mb;
        end
        return e;
    endfunction

    // Monitor: every DONE must match the oldest pending expectation, at its exact cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("lo", lo, e.lo);
                    chk("hi", hi, e.hi);
                    chk("div0", 32'(div0), 32'(e.dz));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    last_hi = e.hi;
                    last_lo = e.lo;
                    last_dz = e.dz;
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                chk("done_missing", 32'(done), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb, input logic es, input int acc_edge);
        exp_t e;
        e = model(ea, eb, es);
        e.cyc = acc_edge + 33;
        sb.push_back(e);
    endtask

    // One operation: wait for IDLE (bounded), pulse START, then scramble operands
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic os);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            chk("idle_timeout", 32'(busy), 32'd0);
        end else begin
            a = oa;
            b = ob;
            sgn = os;
            start = 1'b1;
            push_exp(oa, ob, os, cyc + 1);
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_start", 32'(busy), 32'd1);
            a = $urandom;
            b = $urandom;
            sgn = ~os;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          k0;

    initial begin
        start = 1'b0;
        sgn   = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FF9C, 32'd7, 1'b1);
        do_op(32'd100, 32'hFFFF_FFF9, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h1234_5678, 32'd0, 1'b0);
        do_op(32'h1234_5678, 32'd0, 1'b1);
        do_op(32'h8000_0000, 32'd0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'd5, 32'd9, 1'b0);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 4)  rb = $urandom_range(1, 20);
            else if (sel == 4) rb = 32'hFFFF_FFFF;
            else if (sel == 5) rb = ~32'($urandom_range(0, 20));
            else               rb = $urandom;
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        // Results must hold while inputs wander with START low
        repeat (5) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            sgn = 1'($urandom_range(0, 1));
        end
        chk("hold_hi", hi, last_hi);
        chk("hold_lo", lo, last_lo);
        chk("hold_div0", 32'(div0), 32'(last_dz));

        // START held high: accepts every 35 cycles, operands change mid-operation
        @(negedge clk);
        k0 = cyc + 1;
        for (int n = 0; n < 4; n++) begin
            ra = $urandom;
            rb = (n == 1) ? 32'd0 : 32'($urandom_range(1, 1000));
            a = ra;
            b = rb;
            sgn = 1'b0;
            start = 1'b1;
            push_exp(ra, rb, 1'b0, k0 + 35 * n);
            repeat (34) begin
                @(negedge clk);
                a = $urandom;
                b = $urandom;
            end
            if (n < 3) @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of CALC: operation aborted, outputs cleared
        do_op(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_div0", 32'(div0), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(32'hFFFF_FFFF, 32'h10, 1'b0);
        drain();
        chk("post_rst_lo", lo, 32'h0FFF_FFFF);
        chk("post_rst_hi", hi, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have ports CLK, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port START, input, 1, operation request; sampled only in IDLE.
REQ-004 SHALL have port SIGNED, input, 1, operand interpretation; 1 = two's complement, 0 = unsigned; sampled with START.
REQ-005 SHALL have port A, input, 32, dividend; sampled with START.
REQ-006 SHALL have port B, input, 32, divisor; sampled with START.
REQ-007 SHALL have port HI, output, 32, remainder, registered.
REQ-008 SHALL have port LO, output, 32, quotient, registered.
REQ-009 SHALL have port BUSY, output, 1, high while an operation is in progress.
REQ-010 SHALL have port DONE, output, 1, one-cycle pulse when HI/LO are updated.
REQ-011 SHALL have port DIV0, output, 1, divide-by-zero flag, valid from DONE until the next accepted START.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIN, with transitions IDLE->CALC, CALC->FIN and FIN->IDLE.
REQ-013 IDLE->CALC SHALL occur on a rising edge with START=1, capturing A, B and SIGNED; iteration counter set to 0; BUSY=1 from that edge.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on operand magnitudes for exactly 32 cycles, then go to FIN.
REQ-015 FIN SHALL apply sign correction, load HI/LO/DIV0 and assert DONE for exactly that one cycle, then go to IDLE with BUSY=0.
REQ-016 Latency SHALL be fixed: START accepted at edge k gives DONE=1 in the cycle following edge k+33, for every operand value including B=0.
REQ-017 START while BUSY=1 SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-018 START=1 in the FIN cycle SHALL be ignored; a new START is accepted only in IDLE.
REQ-019 Unsigned mode SHALL satisfy A = LO*B + HI, with HI < B (B nonzero).
REQ-020 Signed mode SHALL truncate toward zero: sign(LO) = sign(A) xor sign(B), sign(HI) = sign(A), |HI| < |B|.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 with DIV0=0.
REQ-022 B=0 SHALL give DIV0=1, LO=0xFFFFFFFF and HI=A, in both modes.
REQ-023 HI, LO and DIV0 SHALL hold their values between DONE pulses; changes to A or B after capture SHALL have no effect.

Reset
REQ-024 RST=0 SHALL immediately force state IDLE, counter 0, HI=0, LO=0, BUSY=0, DONE=0 and DIV0=0, independent of CLK.
REQ-025 Reset during CALC or FIN SHALL abort the operation with no DONE pulse; the first START after RST rises SHALL behave normally.

Configuration
REQ-026 Macro DIV32_SEQ_SIGNED_EN defined SHALL make SIGNED operative, as in REQ-020 and REQ-021.
REQ-027 Macro DIV32_SEQ_SIGNED_EN undefined SHALL omit the sign-handling logic; SIGNED is ignored and all operations are unsigned per REQ-019; port list unchanged.

Verification
REQ-028 Unsigned: A=100, B=7, SIGNED=0 -> DONE after 34 cycles, LO=14, HI=2, DIV0=0.
REQ-029 Signed (macro defined): A=-100 (0xFFFFFF9C), B=7 -> LO=-14 (0xFFFFFFF2), HI=-2 (0xFFFFFFFE); A=100, B=-7 -> LO=-14, HI=2.
REQ-030 Overflow (macro defined): A=0x80000000, B=0xFFFFFFFF, SIGNED=1 -> LO=0x80000000, HI=0; unsigned mode with the same operands -> LO=0, HI=0x80000000.
REQ-031 Divide by zero: A=0x12345678, B=0 -> DIV0=1, LO=0xFFFFFFFF, HI=0x12345678, same 34-cycle latency.
REQ-032 Protocol: START held high throughout and operands changed mid-CALC -> exactly one DONE per accepted START, results from the captured operands, back-to-back operations spaced 35 cycles apart.
REQ-033 Reset: RST=0 asserted between edges at cycle 10 of CALC -> outputs zero immediately, no DONE; then A=0xFFFFFFFF, B=0x10 unsigned -> LO=0x0FFFFFFF, HI=0xF.
